bp_out_wb_streamer: RTL and testbench



---
 rtl/bp_out_wb_streamer.sv | 218 +++++++++++++++++++++
 tb/tb_bp_out_wb_streamer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bp_out_wb_streamer.sv
// bp_out_wb_streamer: write-back reader for the bit-parallel DSP core.
// Walks a range of output-buffer addresses group by group, captures the
// core's registered 64-bit read data into a credit-gated skid FIFO and
// replays it as an AXI4-Stream master with back-pressure.
// Optional feature macro BP_WB_TLAST_EN: mark the final beat of each command
// with m_axis_tlast (a last flag travels with every in-flight read and FIFO
// entry). Without it m_axis_tlast is tied low and the FIFO is data only.
module bp_out_wb_streamer #(
   parameter int unsigned BP_COLS          = 15,
   parameter int unsigned BP_OUT_BUF_DEPTH = 10,
   parameter int unsigned NUM_GRP          = 4,
   parameter int unsigned RD_LAT           = 2,
   parameter int unsigned FIFO_DEPTH       = 8
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  start,
   input  logic [BP_OUT_BUF_DEPTH-1:0]           base_addr,
   input  logic [BP_OUT_BUF_DEPTH:0]             num_addr,
   output logic                                  busy,
   output logic                                  done,
   output logic [2:0]                            bp_out_buf_wb_en,
   output logic [BP_COLS*BP_OUT_BUF_DEPTH-1:0]   bp_out_buf_wb_addr,
   input  logic [63:0]                           bp_out_wb_data,
   output logic [63:0]                           m_axis_tdata,
   output logic                                  m_axis_tvalid,
   input  logic                                  m_axis_tready,
   output logic                                  m_axis_tlast
);

   localparam int unsigned AW  = BP_OUT_BUF_DEPTH;
   localparam int unsigned GW  = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
   localparam int unsigned CW  = AW + 1 + GW;
   localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned IW  = $clog2(RD_LAT + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t              state_q, state_d;
   logic [AW-1:0]       addr_q;
   logic [GW-1:0]       grp_q;
   logic [CW-1:0]       rem_q;
   logic [2:0]          en_q;
   logic                busy_q, done_q;
   logic [RD_LAT-1:0]   pipe_q;
   logic [IW-1:0]       inflight_c;
   logic [63:0]         mem [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [FCW-1:0]      fcnt_q;
   logic                tvalid_q;
   logic [63:0]         tdata_q;
   logic                credit_ok_c, issue_c, accept_c, zero_c, finish_c;
   logic                push_c, load_c, pop_c, bypass_c, wr_c;

   // Population count of the in-flight read pipe
   always_comb begin
      inflight_c = '0;
      for (int i = 0; i < int'(RD_LAT); i++) inflight_c = inflight_c + IW'(pipe_q[i]);
   end

   // FIFO/output-stage handshake decode
   always_comb begin
      credit_ok_c = (32'(fcnt_q) + 32'(inflight_c)) < FIFO_DEPTH;
      push_c      = pipe_q[RD_LAT-1];
      load_c      = !tvalid_q || m_axis_tready;
      pop_c       = load_c && (fcnt_q != '0);
      bypass_c    = load_c && (fcnt_q == '0) && push_c;
      wr_c        = push_c && !bypass_c;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state and command decode
   always_comb begin
      state_d  = state_q;
      issue_c  = 1'b0;
      accept_c = 1'b0;
      zero_c   = 1'b0;
      finish_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (num_addr != '0) begin
                  accept_c = 1'b1;
                  state_d  = RUN;
               end else begin
                  zero_c = 1'b1;
               end
            end
         end
         RUN: begin
            if (credit_ok_c) begin
               issue_c = 1'b1;
               if (rem_q == CW'(1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (inflight_c == '0 && fcnt_q == '0 && (!tvalid_q || m_axis_tready)) begin
               finish_c = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Read issue, in-flight tracking, FIFO control and output register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q   <= '0;
         grp_q    <= '0;
         rem_q    <= '0;
         en_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pipe_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fcnt_q   <= '0;
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
      end else begin
         done_q <= finish_c || zero_c;
         if (accept_c) begin
            busy_q <= 1'b1;
            addr_q <= base_addr;
            grp_q  <= '0;
            rem_q  <= CW'(num_addr) * CW'(NUM_GRP);
         end else if (finish_c) begin
            busy_q <= 1'b0;
         end
         if (issue_c) begin
            en_q  <= 3'(grp_q);
            rem_q <= rem_q - CW'(1);
            if (grp_q == GW'(NUM_GRP - 1)) begin
               grp_q  <= '0;
               addr_q <= addr_q + AW'(1);
            end else begin
               grp_q <= grp_q + GW'(1);
            end
         end
         pipe_q[0] <= issue_c;
         for (int i = 1; i < int'(RD_LAT); i++) pipe_q[i] <= pipe_q[i-1];
         if (wr_c) wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
         if (pop_c) rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
         case ({wr_c, pop_c})
            2'b10:   fcnt_q <= fcnt_q + FCW'(1);
            2'b01:   fcnt_q <= fcnt_q - FCW'(1);
            default: fcnt_q <= fcnt_q;
         endcase
         if (load_c) begin
            if (pop_c) begin
               tvalid_q <= 1'b1;
               tdata_q  <= mem[rd_ptr_q];
            end else if (bypass_c) begin
               tvalid_q <= 1'b1;
               tdata_q  <= bp_out_wb_data;
            end else begin
               tvalid_q <= 1'b0;
            end
         end
      end
   end

   // FIFO storage; contents are don't-care while the count is zero
   always_ff @(posedge clk) begin
      if (wr_c) mem[wr_ptr_q] <= bp_out_wb_data;
   end

   // Credit gating must make a push into a full FIFO impossible
   always_ff @(posedge clk) begin
      if (rst_n && wr_c) assert (fcnt_q < FCW'(FIFO_DEPTH)) else $error("skid fifo push while full");
   end

`ifdef BP_WB_TLAST_EN
   logic [RD_LAT-1:0] lpipe_q;
   logic              lmem [FIFO_DEPTH];
   logic              tlast_q;

   // Last-beat flag follows its read through the pipe, FIFO and output stage
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lpipe_q <= '0;
         tlast_q <= 1'b0;
      end else begin
         lpipe_q[0] <= issue_c && (rem_q == CW'(1));
         for (int i = 1; i < int'(RD_LAT); i++) lpipe_q[i] <= lpipe_q[i-1];
         if (load_c) begin
            if (pop_c)         tlast_q <= lmem[rd_ptr_q];
            else if (bypass_c) tlast_q <= lpipe_q[RD_LAT-1];
            else               tlast_q <= 1'b0;
         end
      end
   end

   // Last-flag storage alongside the data FIFO
   always_ff @(posedge clk) begin
      if (wr_c) lmem[wr_ptr_q] <= lpipe_q[RD_LAT-1];
   end

   assign m_axis_tlast = tlast_q;
`else
   assign m_axis_tlast = 1'b0;
`endif

   assign busy               = busy_q;
   assign done               = done_q;
   assign bp_out_buf_wb_en   = en_q;
   assign bp_out_buf_wb_addr = {BP_COLS{addr_q}};
   assign m_axis_tdata       = tdata_q;
   assign m_axis_tvalid      = tvalid_q;

endmodule

// File: tb/tb_bp_out_wb_streamer.sv
// Directed self-checking bench for bp_out_wb_streamer with a behavioural
// model of the core's two-cycle registered write-back read port.
module tb_bp_out_wb_streamer;

`ifdef BP_WB_TLAST_EN
   localparam bit TLAST_ON = 1'b1;
`else
   localparam bit TLAST_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n, start, tready;
   logic [9:0]    base_addr;
   logic [10:0]   num_addr;
   logic          busy, done, tvalid, tlast;
   logic [2:0]    wb_en;
   logic [149:0]  wb_addr;
   logic [63:0]   wb_data, tdata;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [2:0]    en_log   [64];
   logic [9:0]    addr_log [64];
   logic          busy_log [64];
   logic [149:0]  full1;

   bp_out_wb_streamer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_addr(num_addr),
      .busy(busy), .done(done), .bp_out_buf_wb_en(wb_en), .bp_out_buf_wb_addr(wb_addr),
      .bp_out_wb_data(wb_data), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
      .m_axis_tready(tready), .m_axis_tlast(tlast)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] core_word(input logic [9:0] a, input logic [2:0] g);
      return {(g == 3'd3) ? 16'h0000 : 16'hC0DE, 16'(a), 16'(g), 16'h5A5A};
   endfunction

   // Core model: address registered at t, group mux at t+1, data out at t+2
   logic [9:0] a_d1;
   always @(posedge clk) begin
      a_d1    <= wb_addr[9:0];
      wb_data <= core_word(a_d1, wb_en);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"},   64'(busy),   64'd0);
      chk({tag, "_done"},   64'(done),   64'd0);
      chk({tag, "_wb_en"},  64'(wb_en),  64'd0);
      chk({tag, "_wb_addr"}, 64'(wb_addr == '0), 64'd1);
      chk({tag, "_tvalid"}, 64'(tvalid), 64'd0);
      chk({tag, "_tdata"},  tdata,       64'd0);
      chk({tag, "_tlast"},  64'(tlast),  64'd0);
   endtask

   // Run one command from start to done, checking every beat in order
   task automatic run_job(input logic [9:0] base, input logic [10:0] num, input bit bp,
                          input int restart_cyc, input int budget,
                          output int nbeats, output int done_cyc, output int first_cyc);
      int          total;
      logic        pv, pr;
      logic [63:0] pd;
      logic [9:0]  ea;
      logic [2:0]  eg;
      total = int'(num) * 4;
      nbeats = 0; done_cyc = -1; first_cyc = -1;
      pv = 1'b0; pr = 1'b0; pd = '0;
      base_addr = base; num_addr = num; start = 1'b1; tready = 1'b1;
      tick();
      for (int c = 1; c < budget && done_cyc < 0; c++) begin
         start = (c == restart_cyc);
         if (c == restart_cyc) num_addr = 11'd5;
         tready = bp ? (((c - 1) % 4 == 0) || ((c - 1) % 4 == 3)) : 1'b1;
         if (c < 64) begin
            en_log[c] = wb_en; addr_log[c] = wb_addr[9:0]; busy_log[c] = busy;
         end
         if (c == 1) full1 = wb_addr;
         if (pv && !pr) begin
            chk("stall_tvalid", 64'(tvalid), 64'd1);
            chk("stall_tdata", tdata, pd);
         end
         if (tvalid && first_cyc < 0) first_cyc = c;
         if (tvalid && tready) begin
            ea = base + 10'(nbeats / 4);
            eg = 3'(nbeats % 4);
            chk($sformatf("beat%0d_tdata", nbeats), tdata, core_word(ea, eg));
            chk($sformatf("beat%0d_tlast", nbeats), 64'(tlast),
                64'(TLAST_ON && (nbeats == total - 1)));
            nbeats++;
         end
         if (done) done_cyc = c;
         pv = tvalid; pr = tready; pd = tdata;
         if (done_cyc < 0) tick();
      end
      start = 1'b0;
      chk("job_timeout", 64'(done_cyc < 0), 64'd0);
      chk("job_beats", 64'(nbeats), 64'(total));
      chk("busy_at_done", 64'(busy), 64'd0);
   endtask

   initial begin
      int nb, dc, fc, seen;
      rst_n = 1'b0; start = 1'b0; base_addr = '0; num_addr = '0; tready = 1'b0;
      repeat (3) tick();
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      // Basic two-address job with tready held high
      run_job(10'h010, 11'd2, 1'b0, -1, 100, nb, dc, fc);
      chk("t1_first_tvalid_cycle", 64'(fc), 64'd4);
      chk("t1_done_cycle", 64'(dc), 64'd12);
      chk("t1_busy_cycle1", 64'(busy_log[1]), 64'd1);
      chk("t1_addr_replicated", 64'(full1 == {15{10'h010}}), 64'd1);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t1_wb_en_c%0d", i + 2), 64'(en_log[i + 2]), 64'(i % 4));
         chk($sformatf("t1_wb_addr_c%0d", i + 1), 64'(addr_log[i + 1]), 64'(10'h010 + 10'(i / 4)));
      end

      // Back-pressure 1,0,0,1 over 64 beats
      run_job(10'h100, 11'd16, 1'b1, -1, 600, nb, dc, fc);

      // Address wrap at the top of the buffer
      run_job(10'h3FF, 11'd2, 1'b0, -1, 100, nb, dc, fc);
      chk("t3_addr_first", 64'(addr_log[1]), 64'h3FF);
      chk("t3_addr_wrapped", 64'(addr_log[5]), 64'h000);

      // Zero-length command
      base_addr = 10'h055; num_addr = 11'd0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("t4_done", 64'(done), 64'd1);
      chk("t4_busy", 64'(busy), 64'd0);
      chk("t4_tvalid", 64'(tvalid), 64'd0);
      tick();
      chk("t4_done_pulse_end", 64'(done), 64'd0);
      chk("t4_busy_after", 64'(busy), 64'd0);
      chk("t4_tvalid_after", 64'(tvalid), 64'd0);

      // Reset at beat 5 of a 32-beat job
      base_addr = 10'h020; num_addr = 11'd8; start = 1'b1; tready = 1'b1;
      tick();
      start = 1'b0;
      repeat (7) tick();
      chk("t5_beat5_tvalid", 64'(tvalid), 64'd1);
      chk("t5_beat5_tdata", tdata, core_word(10'h021, 3'd0));
      rst_n = 1'b0;
      tick();
      chk_reset_outputs("t5_midreset");
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (tvalid || done) seen++;
      end
      chk("t5_no_stale_activity", 64'(seen), 64'd0);
      run_job(10'h030, 11'd3, 1'b0, -1, 100, nb, dc, fc);
      chk("t5_rerun_first_tvalid", 64'(fc), 64'd4);
      chk("t5_rerun_done_cycle", 64'(dc), 64'd16);

      // Start pulse while busy is ignored
      run_job(10'h040, 11'd2, 1'b0, 3, 100, nb, dc, fc);
      chk("t6_done_cycle", 64'(dc), 64'd12);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (tvalid || busy) seen++;
      end
      chk("t6_no_second_job", 64'(seen), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
